wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage that feeds the register file's write port. It accepts one retiring instruction per handshake from the memory stage and selects the write-back value: ALU result, load data, or link address. It presents a single-cycle write pulse with destination and data to the register file. Loads stall the stage until the data memory returns the load word.

## Interface
Parameters:
- WIDTH, 32, datapath width.
- TIMEOUT, 16, maximum cycles to wait for load data. Used only when WB_LOAD_TIMEOUT_EN is defined; must be ≥ 2.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- Valid_i  in  1  memory stage presents a retiring instruction.
- Ready_o  out  1  stage accepts this cycle; combinational, equals (state == IDLE).
- Reg_Write_i  in  1  instruction writes a register.
- Mem_To_Reg_i  in  2  source select: 00 ALU, 01 load, 10 link, 11 reserved (treated as ALU).
- Dest_Register_i  in  5  destination register index.
- ALU_Result_i  in  WIDTH  ALU result.
- PC_Plus_4_i  in  WIDTH  link address.
- Load_Valid_i  in  1  data memory returns load data this cycle.
- Load_Data_i  in  WIDTH  load data; sampled only when Load_Valid_i is high in WAIT_LOAD.
- Reg_Write_o  out  1  register-file write enable, single-cycle pulse.
- Write_Register_o  out  5  register-file write index.
- Write_Data_o  out  WIDTH  register-file write data.
- Error_o  out  1  sticky load-timeout flag.

## Operation
- The FSM has two states, IDLE and WAIT_LOAD. Reset state is IDLE.
- An instruction is accepted when Valid_i && Ready_o.
- **IDLE, accept, Mem_To_Reg_i ≠ 01:** on the next edge, Write_Register_o ← Dest_Register_i and Write_Data_o ← ALU_Result_i (00/11) or PC_Plus_4_i (10). Reg_Write_o ← Reg_Write_i && (Dest_Register_i ≠ 0). State stays IDLE.
- **IDLE, accept, Mem_To_Reg_i = 01:** capture Dest_Register_i and Reg_Write_i internally. Reg_Write_o ← 0. State → WAIT_LOAD.
- **WAIT_LOAD with Load_Valid_i:** on the next edge, Write_Data_o ← Load_Data_i and Write_Register_o ← captured index. Reg_Write_o ← captured write flag && (index ≠ 0). State → IDLE.
- **WAIT_LOAD without Load_Valid_i:** hold all state. Reg_Write_o = 0.
- Load_Valid_i in IDLE is ignored.
- Writes to register 0 are always suppressed. Write_Register_o and Write_Data_o still update.
- In any cycle with no write, Reg_Write_o = 0. Write_Register_o and Write_Data_o hold their last value.
- Reset asserted mid-WAIT_LOAD aborts the pending load: no write, state → IDLE.

## Timing
- Reset values: Reg_Write_o 0, Write_Register_o 0, Write_Data_o 0, Error_o 0. Ready_o is 1 while reset is asserted.
- **ALU/link latency:** the write pulse appears 1 cycle after the accept edge. Throughput is 1 per cycle.
- **Load latency:** the write pulse appears 1 cycle after the Load_Valid_i edge. Ready_o is low from the cycle after accept through the Load_Valid_i cycle, and high again in the cycle that carries the write pulse.
- Load data may arrive at the earliest in the cycle after accept. Load_Valid_i in the accept cycle itself is ignored.
- Upstream must hold its inputs stable while Valid_i && !Ready_o. The stage holds no combinational path from any input to Reg_Write_o, Write_Register_o or Write_Data_o.

## Configuration
- Macro: WB_LOAD_TIMEOUT_EN.
- **Defined:**
  - A counter clears on entry to WAIT_LOAD and increments each WAIT_LOAD cycle without Load_Valid_i.
  - When the counter equals TIMEOUT-1 and Load_Valid_i is low, the next state is IDLE with no write, and Error_o is set.
  - Error_o stays set until reset.
  - Load_Valid_i in the timeout cycle wins: a normal write-back occurs and Error_o is not set.
- **Undefined:** WAIT_LOAD waits indefinitely, Error_o is tied 0, and no counter is instantiated.

## Structure
- Shared package wb_pkg holds:
  - the Mem_To_Reg encodings as localparams: WB_SRC_ALU=2'b00, WB_SRC_LOAD=2'b01, WB_SRC_LINK=2'b10;
  - the FSM state encoding: IDLE=1'b0, WAIT_LOAD=1'b1.
- Sub-module wb_load_watchdog holds the timeout counter, width $clog2(TIMEOUT). Inputs: clock, reset, clear, count; output: expired. It is instantiated only under WB_LOAD_TIMEOUT_EN.

## Test plan
- **ALU write:** reset, then accept Mem_To_Reg=00, dest=5, ALU=0x0000_1234, Reg_Write=1 → next cycle Reg_Write_o=1, Write_Register_o=5, Write_Data_o=0x1234 for exactly one cycle.
- **Link write:** accept Mem_To_Reg=10, dest=31, PC_Plus_4=0x0040_0008 → Reg_Write_o=1, Write_Data_o=0x0040_0008. Back-to-back ALU accepts → one pulse per cycle, with no bubble.
- **Load wait:** accept Mem_To_Reg=01, dest=8, then Load_Valid_i 3 cycles later with data 0xDEAD_BEEF → Ready_o low for those 3 cycles, then Reg_Write_o=1, Write_Register_o=8, Write_Data_o=0xDEADBEEF. A Valid_i held meanwhile is accepted only after that.
- **Register 0:** accept dest=0 with Reg_Write=1, ALU=0xFFFF_FFFF → Reg_Write_o stays 0.
- **Reset mid-load:** assert reset during WAIT_LOAD, then present Load_Valid_i after release → no write, Ready_o=1.
- **Timeout (WB_LOAD_TIMEOUT_EN, TIMEOUT=4):** load accepted, no Load_Valid_i → after 4 WAIT_LOAD cycles, Ready_o=1, Error_o=1 sticky, no write. Repeat with Load_Valid_i in the 4th cycle → normal write-back, Error_o=0.

Source files
------------

// File: rtl/wb_pkg.sv
// ----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the write-back stage:
//   - Mem_To_Reg source encodings (ALU, load, link; 2'b11 is reserved and
//     handled like ALU by the stage)
//   - write-back FSM state encoding
//   - helper that applies the register-0 write suppression
// ----------------------------------------------------------------------------
package wb_pkg;

   localparam logic [1:0] WB_SRC_ALU  = 2'b00;
   localparam logic [1:0] WB_SRC_LOAD = 2'b01;
   localparam logic [1:0] WB_SRC_LINK = 2'b10;

   typedef enum logic {
      IDLE      = 1'b0,
      WAIT_LOAD = 1'b1
   } wb_state_e;

   // Register 0 is hard-wired to zero, so a write to it never pulses the
   // register-file write enable.
   function automatic logic write_enable(input logic reg_write, input logic [4:0] dest);
      return reg_write && (dest != 5'd0);
   endfunction

endpackage

// File: rtl/wb_load_watchdog.sv
// ----------------------------------------------------------------------------
// wb_load_watchdog
// Counts cycles spent waiting for load data. Only instantiated by wb_stage
// when WB_LOAD_TIMEOUT_EN is defined.
//
// Ports:
//   clock   in   rising-edge clock
//   reset   in   asynchronous active-low reset
//   clear   in   restart the count (entry into the load wait)
//   count   in   advance the count by one (a wait cycle without load data)
//   expired out  count has reached TIMEOUT-1: this is the last wait cycle
// ----------------------------------------------------------------------------
module wb_load_watchdog #(
   parameter int TIMEOUT = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic count,
   output logic expired
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (count) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = (cnt == LAST);

endmodule

// File: rtl/wb_stage.sv
// ----------------------------------------------------------------------------
// wb_stage
// Write-back stage feeding the register-file write port. Accepts one retiring
// instruction per Valid_i/Ready_o handshake, selects ALU result, load data or
// link address, and issues a registered single-cycle write pulse. Loads park
// the stage in WAIT_LOAD until Load_Valid_i returns the load word.
//
// Handshake: an instruction transfers on a rising edge where Valid_i and
// Ready_o are both high. Ready_o depends only on state (high in IDLE).
// Upstream holds all inputs stable while Valid_i && !Ready_o.
//
// Optional feature: define WB_LOAD_TIMEOUT_EN to abandon a load after TIMEOUT
// wait cycles and raise the sticky Error_o flag. Without it the stage waits
// indefinitely and Error_o is tied low.
//
// Ports:
//   clock, reset        clock, asynchronous active-low reset
//   Valid_i / Ready_o   upstream handshake
//   Reg_Write_i         instruction writes a register
//   Mem_To_Reg_i        source select (00 ALU, 01 load, 10 link, 11 as ALU)
//   Dest_Register_i     destination index
//   ALU_Result_i        ALU result
//   PC_Plus_4_i         link address
//   Load_Valid_i        load data present (only observed in WAIT_LOAD)
//   Load_Data_i         load data
//   Reg_Write_o         write-enable pulse (registered)
//   Write_Register_o    write index (registered, holds between writes)
//   Write_Data_o        write data (registered, holds between writes)
//   Error_o             sticky load-timeout flag
//   debug_state         current FSM state, for observation only
// ----------------------------------------------------------------------------
module wb_stage
   import wb_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             Valid_i,
   output logic             Ready_o,
   input  logic             Reg_Write_i,
   input  logic [1:0]       Mem_To_Reg_i,
   input  logic [4:0]       Dest_Register_i,
   input  logic [WIDTH-1:0] ALU_Result_i,
   input  logic [WIDTH-1:0] PC_Plus_4_i,
   input  logic             Load_Valid_i,
   input  logic [WIDTH-1:0] Load_Data_i,
   output logic             Reg_Write_o,
   output logic [4:0]       Write_Register_o,
   output logic [WIDTH-1:0] Write_Data_o,
   output logic             Error_o,
   output wb_state_e        debug_state
);

   if (TIMEOUT < 2) begin : g_bad_timeout
      $error("wb_stage: TIMEOUT must be at least 2");
   end

   wb_state_e        state, state_next;

   // Destination and write flag of the load being waited on.
   logic [4:0]       pend_dest;
   logic             pend_write;

   // Combinational decisions registered at the next edge.
   logic             wr_update;   // refresh Write_Register_o / Write_Data_o
   logic             wr_pulse;    // drive Reg_Write_o high next cycle
   logic [4:0]       wr_dest;
   logic [WIDTH-1:0] wr_data;
   logic             load_capture;
   logic             wait_idle;   // WAIT_LOAD cycle without load data
   logic             expired;

   assign Ready_o     = (state == IDLE);
   assign debug_state = state;
   assign wait_idle   = (state == WAIT_LOAD) && !Load_Valid_i;

   always_comb begin
      state_next   = state;
      wr_update    = 1'b0;
      wr_pulse     = 1'b0;
      wr_dest      = Dest_Register_i;
      wr_data      = ALU_Result_i;
      load_capture = 1'b0;

      case (state)
         IDLE: begin
            if (Valid_i) begin
               if (Mem_To_Reg_i == WB_SRC_LOAD) begin
                  load_capture = 1'b1;
                  state_next   = WAIT_LOAD;
               end else begin
                  wr_update = 1'b1;
                  wr_pulse  = write_enable(Reg_Write_i, Dest_Register_i);
                  wr_dest   = Dest_Register_i;
                  case (Mem_To_Reg_i)
                     WB_SRC_LINK: wr_data = PC_Plus_4_i;
                     WB_SRC_ALU:  wr_data = ALU_Result_i;
                     default:     wr_data = ALU_Result_i;
                  endcase
               end
            end
         end
         WAIT_LOAD: begin
            // Arriving data wins over a simultaneous timeout.
            if (Load_Valid_i) begin
               wr_update  = 1'b1;
               wr_pulse   = write_enable(pend_write, pend_dest);
               wr_dest    = pend_dest;
               wr_data    = Load_Data_i;
               state_next = IDLE;
            end else if (expired) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         Reg_Write_o      <= 1'b0;
         Write_Register_o <= '0;
         Write_Data_o     <= '0;
         pend_dest        <= '0;
         pend_write       <= 1'b0;
      end else begin
         Reg_Write_o <= wr_pulse;
         if (wr_update) begin
            Write_Register_o <= wr_dest;
            Write_Data_o     <= wr_data;
         end
         if (load_capture) begin
            pend_dest  <= Dest_Register_i;
            pend_write <= Reg_Write_i;
         end
      end
   end

`ifdef WB_LOAD_TIMEOUT_EN
   logic error_q;

   wb_load_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clock   (clock),
      .reset   (reset),
      .clear   (load_capture),
      .count   (wait_idle),
      .expired (expired)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         error_q <= 1'b0;
      end else if (wait_idle && expired) begin
         error_q <= 1'b1;
      end
   end

   assign Error_o = error_q;
`else
   logic unused_wait_idle;
   assign unused_wait_idle = wait_idle;
   assign expired = 1'b0;
   assign Error_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// ----------------------------------------------------------------------------
// tb_wb_stage
// Directed bench for wb_stage. Expected register-file writes ({dest, data})
// are queued when the instruction is driven and popped when the write pulse
// is due. Inputs change and outputs are sampled 1 time unit after the rising
// edge.
// ----------------------------------------------------------------------------
module tb_wb_stage;
   import wb_pkg::*;

   localparam int WIDTH   = 32;
   localparam int TIMEOUT = 4;

   logic             clock;
   logic             reset;
   logic             Valid_i;
   logic             Ready_o;
   logic             Reg_Write_i;
   logic [1:0]       Mem_To_Reg_i;
   logic [4:0]       Dest_Register_i;
   logic [WIDTH-1:0] ALU_Result_i;
   logic [WIDTH-1:0] PC_Plus_4_i;
   logic             Load_Valid_i;
   logic [WIDTH-1:0] Load_Data_i;
   logic             Reg_Write_o;
   logic [4:0]       Write_Register_o;
   logic [WIDTH-1:0] Write_Data_o;
   logic             Error_o;
   wb_state_e        debug_state;

   logic [WIDTH+4:0] exp_q[$];
   int checks   = 0;
   int failures = 0;

   wb_stage #(
      .WIDTH   (WIDTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .Valid_i          (Valid_i),
      .Ready_o          (Ready_o),
      .Reg_Write_i      (Reg_Write_i),
      .Mem_To_Reg_i     (Mem_To_Reg_i),
      .Dest_Register_i  (Dest_Register_i),
      .ALU_Result_i     (ALU_Result_i),
      .PC_Plus_4_i      (PC_Plus_4_i),
      .Load_Valid_i     (Load_Valid_i),
      .Load_Data_i      (Load_Data_i),
      .Reg_Write_o      (Reg_Write_o),
      .Write_Register_o (Write_Register_o),
      .Write_Data_o     (Write_Data_o),
      .Error_o          (Error_o),
      .debug_state      (debug_state)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "simulation time limit");
   end

   // driver / checker tasks
   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_op(input logic [1:0] src, input logic [4:0] dest, input logic rw,
                           input logic [WIDTH-1:0] alu, input logic [WIDTH-1:0] pc);
      Valid_i         = 1'b1;
      Mem_To_Reg_i    = src;
      Dest_Register_i = dest;
      Reg_Write_i     = rw;
      ALU_Result_i    = alu;
      PC_Plus_4_i     = pc;
   endtask

   task automatic expect_write(input string tag);
      logic [WIDTH+4:0] e;
      check({tag, "_we"}, WIDTH'(Reg_Write_o), 1);
      check({tag, "_queued"}, WIDTH'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check({tag, "_reg"}, WIDTH'(Write_Register_o), WIDTH'(e[WIDTH+4:WIDTH]));
         check({tag, "_data"}, Write_Data_o, e[WIDTH-1:0]);
      end
   endtask

   task automatic expect_no_write(input string tag);
      check({tag, "_we"}, WIDTH'(Reg_Write_o), 0);
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      #2;
      check("rst_ready", WIDTH'(Ready_o), 1);
      check("rst_we", WIDTH'(Reg_Write_o), 0);
      check("rst_reg", WIDTH'(Write_Register_o), 0);
      check("rst_data", Write_Data_o, 0);
      check("rst_err", WIDTH'(Error_o), 0);
      cycle();
      reset = 1'b1;
   endtask

   // directed sequence
   initial begin
      reset = 1'b0; Valid_i = 1'b0; Reg_Write_i = 1'b0; Mem_To_Reg_i = 2'b00;
      Dest_Register_i = '0; ALU_Result_i = '0; PC_Plus_4_i = '0;
      Load_Valid_i = 1'b0; Load_Data_i = '0;
      cycle();
      apply_reset();
      cycle();

      // ALU write, single-cycle pulse
      drive_op(WB_SRC_ALU, 5'd5, 1'b1, 32'h0000_1234, 32'h0000_0100);
      exp_q.push_back({5'd5, 32'h0000_1234});
      check("alu_ready", WIDTH'(Ready_o), 1);
      cycle();
      Valid_i = 1'b0;
      expect_write("alu");
      cycle();
      expect_no_write("alu_pulse_end");
      check("alu_hold_reg", WIDTH'(Write_Register_o), 5);
      check("alu_hold_data", Write_Data_o, 32'h0000_1234);

      // Link write followed by back-to-back ALU accepts
      drive_op(WB_SRC_LINK, 5'd31, 1'b1, 32'h1111_1111, 32'h0040_0008);
      exp_q.push_back({5'd31, 32'h0040_0008});
      cycle();
      expect_write("link");
      drive_op(WB_SRC_ALU, 5'd1, 1'b1, 32'hA5A5_0001, 32'h0);
      exp_q.push_back({5'd1, 32'hA5A5_0001});
      cycle();
      expect_write("b2b_alu1");
      drive_op(2'b11, 5'd2, 1'b1, 32'h5A5A_0002, 32'h0BAD_0000);
      exp_q.push_back({5'd2, 32'h5A5A_0002});
      cycle();
      expect_write("b2b_rsvd");
      for (int i = 0; i < 3; i++) begin
         logic [WIDTH-1:0] v;
         v = $urandom_range(32'h7FFF_FFFF, 0);
         drive_op(WB_SRC_ALU, 5'(10 + i), 1'b1, v, 32'h0);
         exp_q.push_back({5'(10 + i), v});
         cycle();
         expect_write("b2b_rand");
      end
      drive_op(WB_SRC_ALU, 5'd3, 1'b0, 32'h0000_0333, 32'h0);
      cycle();
      Valid_i = 1'b0;
      expect_no_write("no_regwrite");
      check("no_regwrite_reg", WIDTH'(Write_Register_o), 3);
      check("no_regwrite_data", Write_Data_o, 32'h0000_0333);

      // Load with data three cycles after accept; load valid in the accept
      // cycle is ignored; a following instruction waits for Ready_o.
      drive_op(WB_SRC_LOAD, 5'd8, 1'b1, 32'h5555_5555, 32'h0);
      Load_Valid_i = 1'b1;
      Load_Data_i  = 32'h1111_0000;
      exp_q.push_back({5'd8, 32'hDEAD_BEEF});
      cycle();
      Load_Valid_i = 1'b0;
      drive_op(WB_SRC_ALU, 5'd9, 1'b1, 32'h0000_0099, 32'h0);
      exp_q.push_back({5'd9, 32'h0000_0099});
      for (int i = 0; i < 3; i++) begin
         check("load_wait_ready", WIDTH'(Ready_o), 0);
         expect_no_write("load_wait");
         if (i == 2) begin
            Load_Valid_i = 1'b1;
            Load_Data_i  = 32'hDEAD_BEEF;
         end
         cycle();
      end
      Load_Valid_i = 1'b0;
      expect_write("load");
      check("load_ready_back", WIDTH'(Ready_o), 1);
      cycle();
      Valid_i = 1'b0;
      expect_write("held_alu");

      // Register 0 suppression, ALU and load paths (load data at earliest)
      drive_op(WB_SRC_ALU, 5'd0, 1'b1, 32'hFFFF_FFFF, 32'h0);
      cycle();
      Valid_i = 1'b0;
      expect_no_write("r0_alu");
      check("r0_alu_reg", WIDTH'(Write_Register_o), 0);
      check("r0_alu_data", Write_Data_o, 32'hFFFF_FFFF);
      drive_op(WB_SRC_LOAD, 5'd0, 1'b1, 32'h0, 32'h0);
      cycle();
      Valid_i = 1'b0;
      Load_Valid_i = 1'b1;
      Load_Data_i  = 32'h0000_ABCD;
      cycle();
      Load_Valid_i = 1'b0;
      expect_no_write("r0_load");
      check("r0_load_data", Write_Data_o, 32'h0000_ABCD);
      check("r0_load_ready", WIDTH'(Ready_o), 1);

      // Load valid while idle is ignored
      Load_Valid_i = 1'b1;
      Load_Data_i  = 32'h0000_0077;
      cycle();
      Load_Valid_i = 1'b0;
      expect_no_write("idle_lv");
      check("idle_lv_data", Write_Data_o, 32'h0000_ABCD);

      // Reset during WAIT_LOAD abandons the load
      drive_op(WB_SRC_LOAD, 5'd12, 1'b1, 32'h0, 32'h0);
      cycle();
      Valid_i = 1'b0;
      check("midrst_wait", WIDTH'(Ready_o), 0);
      apply_reset();
      Load_Valid_i = 1'b1;
      Load_Data_i  = 32'h0000_0C0C;
      cycle();
      Load_Valid_i = 1'b0;
      expect_no_write("midrst");
      check("midrst_ready", WIDTH'(Ready_o), 1);
      check("midrst_reg", WIDTH'(Write_Register_o), 0);

`ifdef WB_LOAD_TIMEOUT_EN
      // Timeout with no data: four wait cycles, then idle with sticky error
      drive_op(WB_SRC_LOAD, 5'd13, 1'b1, 32'h0, 32'h0);
      cycle();
      Valid_i = 1'b0;
      for (int i = 0; i < TIMEOUT; i++) begin
         check("to_wait_ready", WIDTH'(Ready_o), 0);
         check("to_wait_err", WIDTH'(Error_o), 0);
         cycle();
      end
      expect_no_write("to");
      check("to_ready", WIDTH'(Ready_o), 1);
      check("to_err", WIDTH'(Error_o), 1);
      cycle();
      check("to_err_sticky", WIDTH'(Error_o), 1);
      apply_reset();

      // Data in the final wait cycle wins over the timeout
      drive_op(WB_SRC_LOAD, 5'd14, 1'b1, 32'h0, 32'h0);
      exp_q.push_back({5'd14, 32'h0000_4444});
      cycle();
      Valid_i = 1'b0;
      for (int i = 0; i < TIMEOUT; i++) begin
         check("to_lv_wait_ready", WIDTH'(Ready_o), 0);
         if (i == TIMEOUT - 1) begin
            Load_Valid_i = 1'b1;
            Load_Data_i  = 32'h0000_4444;
         end
         cycle();
      end
      Load_Valid_i = 1'b0;
      expect_write("to_lv");
      check("to_lv_err", WIDTH'(Error_o), 0);
`else
      // Without the timeout feature the stage waits indefinitely
      drive_op(WB_SRC_LOAD, 5'd14, 1'b1, 32'h0, 32'h0);
      exp_q.push_back({5'd14, 32'h0000_4444});
      cycle();
      Valid_i = 1'b0;
      repeat (20) cycle();
      check("long_wait_ready", WIDTH'(Ready_o), 0);
      check("long_wait_err", WIDTH'(Error_o), 0);
      expect_no_write("long_wait");
      Load_Valid_i = 1'b1;
      Load_Data_i  = 32'h0000_4444;
      cycle();
      Load_Valid_i = 1'b0;
      expect_write("long_load");
      check("long_err", WIDTH'(Error_o), 0);
`endif

      cycle();
      expect_no_write("final");
      check("queue_drained", WIDTH'(exp_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
